// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small synchronous FIFO.
//
// Words enter through a valid/ready handshake and are sent LSB first with a
// configurable frame: start bit, DATA_BITS data bits, optional parity bit and
// STOP_BITS stop bits. Frames go out back-to-back while the FIFO holds data.
// Every bit lasts exactly DIV = CLOCK_FREQ / BAUD_RATE clock cycles.
//
// Parameter assumptions (not checked in hardware):
//   DIV >= 2, DATA_BITS in 5..9, PARITY in {0,1,2}, STOP_BITS in {1,2},
//   FIFO_DEPTH a power of two and >= 2.

module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,   // 0 = none, 1 = odd, 2 = even
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int DIV   = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    // Wide enough to index up to 9 data bits or 2 stop bits.
    localparam int IDX_W = 4;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q,  level_d;

    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] rd_data;

    // ------------------------------------------------------------------
    // Transmit FSM and datapath registers
    // ------------------------------------------------------------------
    state_t               state_q,   state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 parity_q,  parity_d;
    logic                 tx_q,      tx_d;
    logic                 done_q,    done_d;

    logic                 bit_end;

    // ------------------------------------------------------------------
    // Handshake and FIFO status. Ready depends on the stored level only,
    // so a full FIFO never accepts a word even on a popping cycle.
    // ------------------------------------------------------------------
    assign s_ready    = (level_q != LVL_FULL);
    assign push       = s_valid && s_ready;
    assign fifo_empty = (level_q == '0);
    assign rd_data    = mem_q[rd_ptr_q];

    // Pointer and level next-state; pointers wrap naturally at FIFO_DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO storage write; contents need no reset because the level gates reads.
    // NOTE: storage arrays are left out of reset: flushing is done by clearing
    // the pointers and level, and un-reset memory maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // FIFO pointer and level registers.
    // NOTE: sequential state is updated with non-blocking assignments so that
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    assign bit_end = (bit_cnt_q == CNT_LAST);

    // Next-state, counters, shift register, parity and line level.
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        tx_d      = 1'b1;

        // Cycle counter runs only inside a frame and wraps at the bit boundary,
        // which is also the only point where a state change can happen, so it
        // is cleared on every state entry.
        bit_cnt_d = '0;
        if (state_q != ST_IDLE && !bit_end) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                end
            end

            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == STOP_LAST) begin
                        // Last stop bit done: chain straight into the next
                        // frame when data is waiting, else go idle.
                        done_d    = 1'b1;
                        bit_idx_d = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Load the next word and its parity bit together with the pop.
        if (pop) begin
            shift_d  = rd_data;
            parity_d = (PARITY == 1) ? ~^rd_data : ^rd_data;
        end

        // The line level is registered, so derive it from the next state.
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // FSM and datapath registers; reset abandons any frame and idles the line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE);
    assign tx_done    = done_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.
//
// Four instances cover the frame formats of interest:
//   u0: 8N1, DIV=16      u1: 7E2, DIV=16
//   u2: 7O2, DIV=16      u3: 8N1, 50 MHz / 115200 (DIV=434)
// Inputs are driven 1 time unit after a rising edge; outputs are sampled on
// the falling edge. "Negedge n" is the falling edge after rising edge En.

module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [3:0] valid_w;
    logic [3:0] ready_w;
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;
    logic [2:0] lvl_w [4];
    logic [7:0] data0;
    logic [6:0] data1;
    logic [6:0] data2;
    logic [7:0] data3;

    int total = 0;
    int bad   = 0;

    uart_tx_fifo #(.CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset_n(reset_n), .s_data(data0), .s_valid(valid_w[0]),
        .s_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]),
        .tx_done(done_w[0]), .fifo_level(lvl_w[0]));

    uart_tx_fifo #(.CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .reset_n(reset_n), .s_data(data1), .s_valid(valid_w[1]),
        .s_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]),
        .tx_done(done_w[1]), .fifo_level(lvl_w[1]));

    uart_tx_fifo #(.CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .reset_n(reset_n), .s_data(data2), .s_valid(valid_w[2]),
        .s_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]),
        .tx_done(done_w[2]), .fifo_level(lvl_w[2]));

    uart_tx_fifo #(.CLOCK_FREQ(50000000), .BAUD_RATE(115200), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .reset_n(reset_n), .s_data(data3), .s_valid(valid_w[3]),
        .s_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]),
        .tx_done(done_w[3]), .fifo_level(lvl_w[3]));

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Drive data/valid of one instance.
    task automatic drive(input int idx, input logic [8:0] d, input logic v);
        case (idx)
            0:       data0 = d[7:0];
            1:       data1 = d[6:0];
            2:       data2 = d[6:0];
            default: data3 = d[7:0];
        endcase
        valid_w[idx] = v;
    endtask

    // Push one word into an idle, empty instance and follow its frame.
    // bits holds the expected line levels, first bit in bit 0. Each bit is
    // checked on its first and last cycle, pinning its length to div cycles.
    task automatic send_frame(input string name, input int idx,
                              input logic [8:0] d, input logic [15:0] bits,
                              input int nbits, input int div, input bit full);
        int done_cnt;
        int o;
        int b;
        done_cnt = 0;
        @(posedge clk); #1 drive(idx, d, 1'b1);
        @(posedge clk); #1 drive(idx, d, 1'b0);   // E0: word accepted
        @(negedge clk);
        check({name, " pre tx"},    32'(tx_w[idx]),   32'd1);
        check({name, " pre busy"},  32'(busy_w[idx]), 32'd0);
        check({name, " pre level"}, 32'(lvl_w[idx]),  32'd1);
        for (int n = 1; n <= nbits * div; n++) begin
            @(negedge clk);
            o = n - 1;
            b = o / div;
            if (done_w[idx]) done_cnt++;
            if (n == 1) check({name, " busy rise"}, 32'(busy_w[idx]), 32'd1);
            if ((o % div == 0) || (o % div == div - 1))
                check($sformatf("%s bit%0d cyc%0d", name, b, o % div),
                      32'(tx_w[idx]), 32'(bits[b]));
        end
        if (full) begin
            check({name, " early done"}, 32'(done_cnt), 32'd0);
            @(negedge clk);
            check({name, " done pulse"}, 32'(done_w[idx]), 32'd1);
            check({name, " busy fall"},  32'(busy_w[idx]), 32'd0);
            check({name, " idle tx"},    32'(tx_w[idx]),   32'd1);
            @(negedge clk);
            check({name, " done width"}, 32'(done_w[idx]), 32'd0);
        end
    endtask

    // Hard stop in case something above never returns.
    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          busy_low;
        int          dones;
        int          acc6;
        int          dval;
        int          o;
        int          f;
        int          w;
        int          errs;
        logic        r;
        logic [9:0]  frm;

        reset_n = 1'b0;
        valid_w = '0;
        data0 = '0; data1 = '0; data2 = '0; data3 = '0;

        // ---------------- Reset values ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst u%0d tx", i),    32'(tx_w[i]),    32'd1);
            check($sformatf("rst u%0d ready", i), 32'(ready_w[i]), 32'd1);
            check($sformatf("rst u%0d busy", i),  32'(busy_w[i]),  32'd0);
            check($sformatf("rst u%0d done", i),  32'(done_w[i]),  32'd0);
            check($sformatf("rst u%0d level", i), 32'(lvl_w[i]),   32'd0);
        end
        repeat (100) @(negedge clk);
        check("rst hold tx",   32'(tx_w[0]),   32'd1);
        check("rst hold busy", 32'(busy_w[0]), 32'd0);

        // ---------------- Single frames ----------------
        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        send_frame("8N1 A5", 0, 9'h0A5, 16'h034A, 10, 16, 1'b1);
        // 7E2 0x55: 0,1,0,1,0,1,0,1,p=0,1,1
        send_frame("7E2 55", 1, 9'h055, 16'h06AA, 11, 16, 1'b1);
        // 7E2 0x54: 0,0,0,1,0,1,0,1,p=1,1,1
        send_frame("7E2 54", 1, 9'h054, 16'h07A8, 11, 16, 1'b1);
        // 7O2 0x55: 0,1,0,1,0,1,0,1,p=1,1,1
        send_frame("7O2 55", 2, 9'h055, 16'h07AA, 11, 16, 1'b1);
        // DIV = 50000000/115200 = 434: first three bits 0,1,0
        send_frame("div434", 3, 9'h0A5, 16'h0002, 3, 434, 1'b0);

        // ---------------- Fill and back-to-back ----------------
        busy_low = 0;
        dones    = 0;
        acc6     = -1;
        errs     = 0;
        @(posedge clk); #1 dval = 1; drive(0, 9'(dval), 1'b1);
        @(posedge clk);                       // E0: 0x01 accepted
        #1 dval = 2; drive(0, 9'(dval), 1'b1);
        for (int n = 0; n <= 961; n++) begin
            @(negedge clk);
            r = ready_w[0];
            if (n == 0) check("fill lvl E0", 32'(lvl_w[0]), 32'd1);
            if (n == 4) begin
                check("fill lvl E4",   32'(lvl_w[0]),   32'd4);
                check("fill ready E4", 32'(ready_w[0]), 32'd0);
            end
            if (n >= 1 && n <= 961 && done_w[0]) dones++;
            if (n >= 1 && n <= 960) begin
                if (!busy_w[0]) busy_low++;
                o   = n - 1;
                f   = o / 160;
                w   = o % 160;
                frm = {1'b1, 8'(f + 1), 1'b0};
                if (w % 16 == 8)
                    check($sformatf("fill f%0d bit%0d", f, w / 16),
                          32'(tx_w[0]), 32'(frm[w / 16]));
            end
            if (n == 161) begin
                check("fill chain done", 32'(done_w[0]), 32'd1);
                check("fill chain tx",   32'(tx_w[0]),   32'd0);
                check("fill chain busy", 32'(busy_w[0]), 32'd1);
            end
            if (n == 961) begin
                check("fill end done",  32'(done_w[0]), 32'd1);
                check("fill end busy",  32'(busy_w[0]), 32'd0);
                check("fill end level", 32'(lvl_w[0]),  32'd0);
            end
            @(posedge clk);                   // E(n+1)
            #1;
            if (valid_w[0] && r) begin
                if (dval == 6) begin
                    acc6 = n + 1;
                    drive(0, 9'h000, 1'b0);
                end else begin
                    dval++;
                    drive(0, 9'(dval), 1'b1);
                end
            end
        end
        check("fill dones",     32'(dones),    32'd6);
        check("fill busy gaps", 32'(busy_low), 32'd0);
        check("fill acc 0x06",  32'(acc6),     32'd162);

        // ---------------- Reset mid-frame ----------------
        @(posedge clk); #1 drive(0, 9'h03C, 1'b1);
        @(posedge clk); #1 drive(0, 9'h011, 1'b1);   // E0: 0x3C pushed
        @(posedge clk); #1 drive(0, 9'h022, 1'b1);   // E1: pop 0x3C, push 0x11
        @(posedge clk); #1 drive(0, 9'h000, 1'b0);   // E2: push 0x22
        repeat (48) @(posedge clk);                  // E50
        #2;
        check("midrst pre level", 32'(lvl_w[0]),  32'd2);
        check("midrst pre busy",  32'(busy_w[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst tx",    32'(tx_w[0]),    32'd1);
        check("midrst level", 32'(lvl_w[0]),   32'd0);
        check("midrst ready", 32'(ready_w[0]), 32'd1);
        check("midrst busy",  32'(busy_w[0]),  32'd0);
        check("midrst done",  32'(done_w[0]),  32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!tx_w[0] || busy_w[0] || done_w[0]) errs++;
        end
        check("midrst quiet", 32'(errs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, configurable frame format and a valid/ready upstream handshake. It sits between the hasher's result formatter and the `tx` pin. It buffers up to `FIFO_DEPTH` words and sends them back-to-back with no idle gap. It supersedes the fixed 8N1 transmitter and adds parity, 5–9 data bits, 1–2 stop bits and exact per-bit timing.

## Interface

- `CLOCK_FREQ`, default 50000000: clk frequency in Hz.
- `BAUD_RATE`, default 9600: line rate. `DIV = CLOCK_FREQ / BAUD_RATE` (truncating) and must be ≥ 2.
- `DATA_BITS`, default 8: data bits per frame, legal range 5–9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 4: power of two, ≥ 2.

Ports:

- `clk` in 1: clock. Reset `reset_n`, asynchronous, active-low; clock `clk`.
- `reset_n` in 1: asynchronous active-low reset.
- `s_data` in `DATA_BITS`: word to send. Sent LSB first.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: FIFO can accept a word. Equals (level != `FIFO_DEPTH`).
- `tx` out 1: serial line, idle high. Registered output.
- `busy` out 1: high while a frame is on the line (state != IDLE).
- `tx_done` out 1: one-cycle pulse when the last stop bit completes.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: number of words stored.

## Operation

- **Push:** a word is written when `s_valid && s_ready` at a rising edge. The push is ignored when full; upstream must hold `s_data` until accepted.
- **Pop:** a word is popped when the FSM is in IDLE with the FIFO non-empty, or when the final stop bit ends with the FIFO non-empty.
  - On pop the shift register is loaded and the parity bit is computed: even = `^data`, odd = `~^data`.
- **Simultaneous push and pop:** `fifo_level` is unchanged. `s_ready` is computed from the current level only; there is no full-FIFO pass-through. There is no empty-FIFO bypass either: every word passes through the FIFO.
- **Pointers:** read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
- **FSM states:** IDLE, START, DATA, PARITY, STOP. Each state lasts a whole number of bit periods.
  - IDLE → START on pop.
  - START → DATA after 1 bit period.
  - DATA → PARITY after `DATA_BITS` bit periods if `PARITY` != 0, otherwise DATA → STOP.
  - PARITY → STOP after 1 bit period.
  - At the end of STOP (`STOP_BITS` bit periods): go to START if the FIFO is non-empty (popping on that edge), otherwise go to IDLE.
- **Bit counter:** counts 0..`DIV`-1, so each bit period is exactly `DIV` cycles. It clears on every state entry.
- **Line levels:** `tx` = 0 in START, the current data bit in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
- **Reset (asynchronous, including mid-frame):** `tx`=1, `busy`=0, `tx_done`=0, `fifo_level`=0, `s_ready`=1, FSM=IDLE, FIFO flushed, counters cleared. A partial frame is abandoned and the line goes high immediately.

## Timing

- **Latency:** with an empty FIFO and IDLE FSM, a push at edge E0 pops at E1. `tx` falls after E1 and `busy` rises after E1.
- **Frame length:** (1 + `DATA_BITS` + (`PARITY`!=0) + `STOP_BITS`) × `DIV` cycles.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the last stop-bit cycle, with zero idle cycles.
- **`tx_done`:** high for the one cycle following the edge that ends STOP, including when the FSM goes straight back to START.
- **`busy`:** falls on that same edge only if the FSM returns to IDLE.

## Test plan

Use `CLOCK_FREQ`=16 and `BAUD_RATE`=1 (`DIV`=16) unless noted.

1. **Reset values:** assert `reset_n`=0, then release it. Required: `tx`=1, `s_ready`=1, `busy`=0, `tx_done`=0, `fifo_level`=0, held indefinitely with `s_valid`=0.
2. **8N1 frame:** push 0xA5 at E0. Required: from E1, `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles (160 total). `tx_done` pulses once at cycle 160 after E1. `busy` falls with it.
3. **7E2 frame** (`DATA_BITS`=7, `PARITY`=2, `STOP_BITS`=2): push 7'h55. Required: 0,1,0,1,0,1,0,1, parity 0, then 1,1, for 11×16 cycles. Repeat with 7'h54: parity bit 1. Repeat with `PARITY`=1 on 7'h55: parity bit 1.
4. **Fill and back-to-back:** hold `s_valid`=1 and push 0x01..0x06 (`FIFO_DEPTH`=4). Required:
   - 0x01 pops at E1; 0x02–0x05 are accepted on E1–E4; `fifo_level`=4 and `s_ready`=0 from E4.
   - 0x06 is accepted only after 0x02 pops at the end of frame 1.
   - All six frames are contiguous (6×160 cycles, no idle gap) and exactly 6 `tx_done` pulses occur.
5. **Reset mid-frame:** push 0x3C, then drop `reset_n` at cycle 50 of the frame with 2 words queued. Required: `tx`=1 and `fifo_level`=0 asynchronously. After release, no further frames are sent.
6. **Divisor truncation:** with `CLOCK_FREQ`=50000000 and `BAUD_RATE`=115200, each bit lasts exactly 434 cycles; check the first 3 bits of a frame with a cycle counter.
